// File: rtl/typedefs_pkg.sv
// Shared types for the execute datapath: ALU operation encoding.
package typedefs_pkg;

  // ALU operation select; the numeric order is part of the instruction
  // decode contract and must not be reordered.
  typedef enum logic [3:0] {
    ALU_AND  = 4'd0,
    ALU_OR   = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_XOR  = 4'd3,
    ALU_SUB  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } aluop_sel_t;

  // Shift amounts are always taken from the low five bits of operand 2.
  localparam int unsigned SHAMT_W = 5;

endpackage

// File: rtl/alu.sv
// Integer ALU for RV32I register/immediate ops. Carry, borrow and
// overflow are discarded; unused operation codes produce zero.
module alu
  import typedefs_pkg::*;
#(
  parameter int DWIDTH = 32
) (
  input  aluop_sel_t        alu_sel,
  input  logic [DWIDTH-1:0] src1,
  input  logic [DWIDTH-1:0] src2,
  output logic [DWIDTH-1:0] res,
  output logic              res_is_0
);

  logic signed [DWIDTH-1:0] src1_s;
  logic signed [DWIDTH-1:0] src2_s;
  logic        [SHAMT_W-1:0] shamt;

  assign src1_s = src1;
  assign src2_s = src2;
  assign shamt  = src2[SHAMT_W-1:0];

  // Operation decode; comparisons return a single LSB.
  always_comb begin
    res = '0;
    case (alu_sel)
      ALU_AND:  res = src1 & src2;
      ALU_OR:   res = src1 | src2;
      ALU_ADD:  res = src1 + src2;
      ALU_XOR:  res = src1 ^ src2;
      ALU_SUB:  res = src1 - src2;
      ALU_SLT:  res = DWIDTH'(src1_s < src2_s);
      ALU_SLTU: res = DWIDTH'(src1 < src2);
      ALU_SLL:  res = src1 << shamt;
      ALU_SRL:  res = src1 >> shamt;
      ALU_SRA:  res = src1_s >>> shamt;
      default:  res = '0;
    endcase
  end

  assign res_is_0 = (res == '0);

endmodule

// File: rtl/mux.sv
// Generic N-input one-hot-free selector; out-of-range selects yield zero.
module mux #(
  parameter int N_INPUTS = 2,
  parameter int DWIDTH   = 32,
  localparam int SW      = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1
) (
  input  logic [N_INPUTS-1:0][DWIDTH-1:0] in_data,
  input  logic [SW-1:0]                   sel,
  output logic [DWIDTH-1:0]               out_data
);

  // Pick the input whose index matches the select.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      if (sel == SW'(i)) begin
        out_data = in_data[i];
      end
    end
  end

endmodule

// File: rtl/register_bank.sv
// Register file: 2**AWIDTH words, two combinational read ports, one
// synchronous write port. Register 0 is hard-wired to zero.
// Optional macro DATAPATH_FWD_EN: a write in flight is forwarded to any
// read port addressing the same register in the same cycle.
module register_bank #(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wen,
  output logic [DWIDTH-1:0] rdata1,
  output logic [DWIDTH-1:0] rdata2
);

  localparam int NREGS = 2 ** AWIDTH;

  logic [DWIDTH-1:0] regs_q [NREGS];

  // Reset clears every word; otherwise store write data, ignoring address 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wen && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

`ifdef DATAPATH_FWD_EN
  logic fwd_vld;
  assign fwd_vld = wen && !rst && (waddr != '0);

  // Read ports with bypass of the write currently being presented.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = (fwd_vld && (raddr1 == waddr)) ? wdata : regs_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = (fwd_vld && (raddr2 == waddr)) ? wdata : regs_q[raddr2];
    end
  end
`else
  // Read ports return stored contents only; address 0 always reads zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != '0) begin
      rdata1 = regs_q[raddr1];
    end
    if (raddr2 != '0) begin
      rdata2 = regs_q[raddr2];
    end
  end
`endif

endmodule

// File: rtl/alu_datapath.sv
// Execute datapath: register file feeding an ALU, with operand 2 chosen
// between read port 2 and an external constant/immediate.
// Optional macro DATAPATH_FWD_EN enables write-to-read forwarding in the
// register file; the default build reads stored contents only.
module alu_datapath
  import typedefs_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] raddr1,
  input  logic [AWIDTH-1:0] raddr2,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              wen,
  input  aluop_sel_t        alu_sel,
  input  logic              mux_sel,
  input  logic [DWIDTH-1:0] some_const,
  output logic [DWIDTH-1:0] rdata1,
  output logic [DWIDTH-1:0] rdata2,
  output logic [DWIDTH-1:0] src2,
  output logic [DWIDTH-1:0] res,
  output logic              res_is_0
);

  logic [1:0][DWIDTH-1:0] op2_cand;

  register_bank #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH)
  ) u_register_bank (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (raddr1),
    .raddr2 (raddr2),
    .waddr  (waddr),
    .wdata  (wdata),
    .wen    (wen),
    .rdata1 (rdata1),
    .rdata2 (rdata2)
  );

  // Index 0 is the register operand, index 1 the immediate.
  assign op2_cand[0] = rdata2;
  assign op2_cand[1] = some_const;

  mux #(
    .N_INPUTS (2),
    .DWIDTH   (DWIDTH)
  ) u_mux (
    .in_data  (op2_cand),
    .sel      (mux_sel),
    .out_data (src2)
  );

  alu #(
    .DWIDTH (DWIDTH)
  ) u_alu (
    .alu_sel  (alu_sel),
    .src1     (rdata1),
    .src2     (src2),
    .res      (res),
    .res_is_0 (res_is_0)
  );

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath with hand-computed expected values.
module tb_alu_datapath;
  import typedefs_pkg::*;

  logic        clk;
  logic        rst;
  logic [2:0]  raddr1;
  logic [2:0]  raddr2;
  logic [2:0]  waddr;
  logic [31:0] wdata;
  logic        wen;
  aluop_sel_t  alu_sel;
  logic        mux_sel;
  logic [31:0] some_const;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic [31:0] src2;
  logic [31:0] res;
  logic        res_is_0;

  int n_tests;
  int n_fail;

  alu_datapath #(
    .AWIDTH (3),
    .DWIDTH (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .raddr1     (raddr1),
    .raddr2     (raddr2),
    .waddr      (waddr),
    .wdata      (wdata),
    .wen        (wen),
    .alu_sel    (alu_sel),
    .mux_sel    (mux_sel),
    .some_const (some_const),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .src2       (src2),
    .res        (res),
    .res_is_0   (res_is_0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wen   = 1'b1;
    waddr = a;
    wdata = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  task automatic op_chk(input string tag, input aluop_sel_t op,
                        input logic [31:0] exp_res, input logic exp_z);
    alu_sel = op;
    #1;
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_z"}, {31'd0, res_is_0}, {31'd0, exp_z});
  endtask

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    raddr1     = '0;
    raddr2     = '0;
    waddr      = '0;
    wdata      = '0;
    wen        = 1'b0;
    alu_sel    = ALU_ADD;
    mux_sel    = 1'b0;
    some_const = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    raddr1 = 3'd3;
    raddr2 = 3'd5;
    #1;
    chk("rst_rdata1", rdata1, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    op_chk("rst_add", ALU_ADD, 32'h0, 1'b1);

    // Write every address, address 0 must stay zero
    for (int a = 0; a < 8; a++) begin
      wr(3'(a), 32'hDEADBEEF);
    end
    for (int a = 0; a < 8; a++) begin
      raddr1 = 3'(a);
      raddr2 = 3'(7 - a);
      #1;
      chk($sformatf("rd1_a%0d", a), rdata1, (a == 0) ? 32'h0 : 32'hDEADBEEF);
      chk($sformatf("rd2_a%0d", 7 - a), rdata2, (a == 7) ? 32'h0 : 32'hDEADBEEF);
    end

    // Register operands: 5 and -5
    wr(3'd1, 32'h00000005);
    wr(3'd2, 32'hFFFFFFFB);
    raddr1  = 3'd1;
    raddr2  = 3'd2;
    mux_sel = 1'b0;
    some_const = 32'h12345678;
    #1;
    chk("src2_reg", src2, 32'hFFFFFFFB);
    op_chk("add",  ALU_ADD,  32'h00000000, 1'b1);
    op_chk("sub",  ALU_SUB,  32'h0000000A, 1'b0);
    op_chk("slt",  ALU_SLT,  32'h00000000, 1'b1);
    op_chk("sltu", ALU_SLTU, 32'h00000001, 1'b0);
    op_chk("xor",  ALU_XOR,  32'hFFFFFFFE, 1'b0);
    op_chk("and",  ALU_AND,  32'h00000001, 1'b0);
    op_chk("or",   ALU_OR,   32'hFFFFFFFF, 1'b0);
    // Swap operands: -5 < 5 signed, but not unsigned
    raddr1 = 3'd2;
    raddr2 = 3'd1;
    op_chk("slt_sw",  ALU_SLT,  32'h00000001, 1'b0);
    op_chk("sltu_sw", ALU_SLTU, 32'h00000000, 1'b1);

    // Immediate operand shifts on 0x80000000
    wr(3'd3, 32'h80000000);
    raddr1     = 3'd3;
    mux_sel    = 1'b1;
    some_const = 32'h00000002;
    #1;
    chk("src2_imm", src2, 32'h00000002);
    op_chk("sll", ALU_SLL, 32'h00000000, 1'b1);
    op_chk("srl", ALU_SRL, 32'h20000000, 1'b0);
    op_chk("sra", ALU_SRA, 32'hE0000000, 1'b0);

    // Shift amount is masked to five bits
    wr(3'd1, 32'h00000001);
    raddr1     = 3'd1;
    some_const = 32'h00000023;
    op_chk("sll_mask", ALU_SLL, 32'h00000008, 1'b0);
    raddr1 = 3'd3;
    op_chk("sra_mask", ALU_SRA, 32'hF0000000, 1'b0);

    // Undefined op codes yield zero even with nonzero operands
    op_chk("op12", aluop_sel_t'(4'd12), 32'h0, 1'b1);
    op_chk("op15", aluop_sel_t'(4'd15), 32'h0, 1'b1);

    // Same-cycle read of the write address
    wr(3'd2, 32'h00000011);
    @(negedge clk);
    raddr1 = 3'd2;
    wen    = 1'b1;
    waddr  = 3'd2;
    wdata  = 32'h00000055;
    #1;
`ifdef DATAPATH_FWD_EN
    chk("fwd_pre", rdata1, 32'h00000055);
`else
    chk("fwd_pre", rdata1, 32'h00000011);
`endif
    @(posedge clk);
    #1;
    wen = 1'b0;
    chk("fwd_post", rdata1, 32'h00000055);

    // Reset beats a simultaneous write
    wr(3'd4, 32'h00000077);
    raddr1 = 3'd4;
    #1;
    chk("pre_rst_r4", rdata1, 32'h00000077);
    @(negedge clk);
    rst   = 1'b1;
    wen   = 1'b1;
    waddr = 3'd4;
    wdata = 32'h00001234;
    @(posedge clk);
    #1;
    rst = 1'b0;
    wen = 1'b0;
    raddr1 = 3'd4;
    raddr2 = 3'd2;
    mux_sel = 1'b0;
    #1;
    chk("rstwr_r4", rdata1, 32'h0);
    chk("rstwr_r2", rdata2, 32'h0);
    op_chk("rstwr_add", ALU_ADD, 32'h0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
